// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, integer ALU, branch/jump resolution,
// registered EX/MEM output slot and a one-cycle PC redirect for taken control flow.
module ex_stage (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        id_valid_i,
  output logic        id_ready_o,
  input  logic [63:0] id_pc_i,
  input  logic [63:0] id_rs1_data_i,
  input  logic [63:0] id_rs2_data_i,
  input  logic [63:0] id_imm_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic [4:0]  id_rd_addr_i,
  input  logic        id_rd_we_i,
  input  logic [3:0]  id_alu_op_i,
  input  logic        id_a_sel_i,
  input  logic        id_b_sel_i,
  input  logic [2:0]  id_br_type_i,
  input  logic        mem_fwd_we_i,
  input  logic [4:0]  mem_fwd_rd_i,
  input  logic [63:0] mem_fwd_data_i,
  input  logic        wb_fwd_we_i,
  input  logic [4:0]  wb_fwd_rd_i,
  input  logic [63:0] wb_fwd_data_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [63:0] ex_result_o,
  output logic [63:0] ex_store_data_o,
  output logic [4:0]  ex_rd_addr_o,
  output logic        ex_rd_we_o,
  output logic [63:0] ex_pc_o,
  output logic        redirect_o,
  output logic [63:0] redirect_pc_o
);

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned REG_AW     = 5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_COPY = 4'd10;
  localparam logic [3:0] OP_ADDW = 4'd11;
  localparam logic [3:0] OP_SUBW = 4'd12;
  localparam logic [3:0] OP_SLLW = 4'd13;
  localparam logic [3:0] OP_SRLW = 4'd14;
  localparam logic [3:0] OP_SRAW = 4'd15;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;
  localparam logic [2:0] BR_JUMP = 3'd7;

  logic [DATA_WIDTH-1:0] rs1_fwd_c, rs2_fwd_c;
  logic [DATA_WIDTH-1:0] alu_a_c, alu_b_c, alu_res_c;
  logic [31:0]           w_res_c;
  logic [DATA_WIDTH-1:0] target_c, result_c;
  logic                  taken_c, squash_c, take_c;
  logic [REG_AW-1:0]     rs1_c, rs2_c;

  assign rs1_c = id_rs1_addr_i;
  assign rs2_c = id_rs2_addr_i;

  // A redirect or flush turns the upstream port into a discard sink.
  assign squash_c   = redirect_o || flush_i;
  assign id_ready_o = !ex_valid_o || ex_ready_i || squash_c;
  assign take_c     = id_valid_i && id_ready_o && !squash_c;

  // rs1 bypass: own slot, then MEM, then WB, then register file; x0 never forwarded.
  always_comb begin
    rs1_fwd_c = id_rs1_data_i;
    if (rs1_c != '0) begin
      if (ex_valid_o && ex_rd_we_o && ex_rd_addr_o == rs1_c) rs1_fwd_c = ex_result_o;
      else if (mem_fwd_we_i && mem_fwd_rd_i == rs1_c)       rs1_fwd_c = mem_fwd_data_i;
      else if (wb_fwd_we_i && wb_fwd_rd_i == rs1_c)         rs1_fwd_c = wb_fwd_data_i;
    end
  end

  // rs2 bypass, same priority as rs1.
  always_comb begin
    rs2_fwd_c = id_rs2_data_i;
    if (rs2_c != '0) begin
      if (ex_valid_o && ex_rd_we_o && ex_rd_addr_o == rs2_c) rs2_fwd_c = ex_result_o;
      else if (mem_fwd_we_i && mem_fwd_rd_i == rs2_c)       rs2_fwd_c = mem_fwd_data_i;
      else if (wb_fwd_we_i && wb_fwd_rd_i == rs2_c)         rs2_fwd_c = wb_fwd_data_i;
    end
  end

  assign alu_a_c = id_a_sel_i ? id_pc_i  : rs1_fwd_c;
  assign alu_b_c = id_b_sel_i ? id_imm_i : rs2_fwd_c;

  // ALU: 64-bit ops plus 32-bit W ops sign-extended to 64 bits.
  always_comb begin
    w_res_c   = '0;
    alu_res_c = '0;
    unique case (id_alu_op_i)
      OP_ADD:  alu_res_c = alu_a_c + alu_b_c;
      OP_SUB:  alu_res_c = alu_a_c - alu_b_c;
      OP_OR:   alu_res_c = alu_a_c | alu_b_c;
      OP_AND:  alu_res_c = alu_a_c & alu_b_c;
      OP_XOR:  alu_res_c = alu_a_c ^ alu_b_c;
      OP_SLL:  alu_res_c = alu_a_c << alu_b_c[5:0];
      OP_SRL:  alu_res_c = alu_a_c >> alu_b_c[5:0];
      OP_SRA:  alu_res_c = DATA_WIDTH'($signed(alu_a_c) >>> alu_b_c[5:0]);
      OP_SLT:  alu_res_c = DATA_WIDTH'($signed(alu_a_c) < $signed(alu_b_c));
      OP_SLTU: alu_res_c = DATA_WIDTH'(alu_a_c < alu_b_c);
      OP_COPY: alu_res_c = alu_b_c;
      default: begin
        unique case (id_alu_op_i)
          OP_ADDW: w_res_c = alu_a_c[31:0] + alu_b_c[31:0];
          OP_SUBW: w_res_c = alu_a_c[31:0] - alu_b_c[31:0];
          OP_SLLW: w_res_c = alu_a_c[31:0] << alu_b_c[4:0];
          OP_SRLW: w_res_c = alu_a_c[31:0] >> alu_b_c[4:0];
          default: w_res_c = 32'($signed(alu_a_c[31:0]) >>> alu_b_c[4:0]);
        endcase
        alu_res_c = {{32{w_res_c[31]}}, w_res_c};
      end
    endcase
  end

  // Branch condition on forwarded operands, target and slot result.
  always_comb begin
    taken_c = 1'b0;
    unique case (id_br_type_i)
      BR_NONE: taken_c = 1'b0;
      BR_BEQ:  taken_c = (rs1_fwd_c == rs2_fwd_c);
      BR_BNE:  taken_c = (rs1_fwd_c != rs2_fwd_c);
      BR_BLT:  taken_c = ($signed(rs1_fwd_c) <  $signed(rs2_fwd_c));
      BR_BGE:  taken_c = ($signed(rs1_fwd_c) >= $signed(rs2_fwd_c));
      BR_BLTU: taken_c = (rs1_fwd_c <  rs2_fwd_c);
      BR_BGEU: taken_c = (rs1_fwd_c >= rs2_fwd_c);
      default: taken_c = 1'b1;
    endcase
    if (id_br_type_i == BR_JUMP) begin
      target_c = {alu_res_c[DATA_WIDTH-1:1], 1'b0};
      result_c = id_pc_i + DATA_WIDTH'(4);
    end else begin
      target_c = id_pc_i + id_imm_i;
      result_c = alu_res_c;
    end
  end

  // Output slot and redirect registers; flush outranks any transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_o      <= 1'b0;
      ex_result_o     <= '0;
      ex_store_data_o <= '0;
      ex_rd_addr_o    <= '0;
      ex_rd_we_o      <= 1'b0;
      ex_pc_o         <= '0;
      redirect_o      <= 1'b0;
      redirect_pc_o   <= '0;
    end else begin
      redirect_o <= take_c && taken_c;
      if (take_c && taken_c) redirect_pc_o <= target_c;
      if (flush_i) begin
        ex_valid_o <= 1'b0;
      end else if (take_c) begin
        ex_valid_o      <= 1'b1;
        ex_result_o     <= result_c;
        ex_store_data_o <= rs2_fwd_c;
        ex_rd_addr_o    <= id_rd_addr_i;
        ex_rd_we_o      <= id_rd_we_i;
        ex_pc_o         <= id_pc_i;
      end else if (ex_ready_i) begin
        ex_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus randomized traffic against a
// transaction-level reference model of the execute stage.
module tb_ex_stage;

  logic        clk, rst_n, flush;
  logic        id_valid, id_ready;
  logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_rd_we;
  logic [3:0]  id_alu_op;
  logic        id_a_sel, id_b_sel;
  logic [2:0]  id_br_type;
  logic        mem_we, wb_we;
  logic [4:0]  mem_rd, wb_rd;
  logic [63:0] mem_data, wb_data;
  logic        ex_valid, ex_ready;
  logic [63:0] ex_result, ex_store, ex_pc;
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic        redirect;
  logic [63:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  // Reference model of the slot as seen from outside.
  logic        m_valid, m_we, m_redir;
  logic [63:0] m_result, m_store, m_pc, m_redir_pc;
  logic [4:0]  m_rd;

  ex_stage dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .id_valid_i(id_valid), .id_ready_o(id_ready),
    .id_pc_i(id_pc), .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm),
    .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr), .id_rd_addr_i(id_rd_addr),
    .id_rd_we_i(id_rd_we), .id_alu_op_i(id_alu_op), .id_a_sel_i(id_a_sel), .id_b_sel_i(id_b_sel),
    .id_br_type_i(id_br_type),
    .mem_fwd_we_i(mem_we), .mem_fwd_rd_i(mem_rd), .mem_fwd_data_i(mem_data),
    .wb_fwd_we_i(wb_we), .wb_fwd_rd_i(wb_rd), .wb_fwd_data_i(wb_data),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
    .ex_result_o(ex_result), .ex_store_data_o(ex_store),
    .ex_rd_addr_o(ex_rd), .ex_rd_we_o(ex_we), .ex_pc_o(ex_pc),
    .redirect_o(redirect), .redirect_pc_o(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Shifts expressed as multiply/divide by powers of two.
  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] p;
    logic [31:0] p32, aw, bw;
    p   = 64'd1 << b[5:0];
    p32 = 32'd1 << b[4:0];
    aw  = a[31:0];
    bw  = b[31:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a | b;
      4'd3:  return a & b;
      4'd4:  return a ^ b;
      4'd5:  return a * p;
      4'd6:  return a / p;
      4'd7:  return a[63] ? ~((~a) / p) : a / p;
      4'd8:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd9:  return (a < b) ? 64'd1 : 64'd0;
      4'd10: return b;
      4'd11: return sext32(aw + bw);
      4'd12: return sext32(aw - bw);
      4'd13: return sext32(aw * p32);
      4'd14: return sext32(aw / p32);
      default: return sext32(aw[31] ? ~((~aw) / p32) : aw / p32);
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] br, input logic [63:0] x, input logic [63:0] y);
    case (br)
      3'd1: return x == y;
      3'd2: return x != y;
      3'd3: return $signed(x) < $signed(y);
      3'd4: return $signed(x) >= $signed(y);
      3'd5: return x < y;
      3'd6: return x >= y;
      3'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Most recent producer wins; x0 is hard-wired to the register-file value.
  function automatic logic [63:0] ref_fwd(input logic [4:0] rs, input logic [63:0] rf);
    if (rs == 5'd0) return rf;
    if (m_valid && m_we && m_rd == rs) return m_result;
    if (mem_we && mem_rd == rs) return mem_data;
    if (wb_we && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  function automatic logic ref_ready();
    return !m_valid || ex_ready || m_redir || flush;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_redir = 0; m_result = 0; m_store = 0;
    m_pc = 0; m_redir_pc = 0; m_rd = 0;
  endtask

  // Advance one clock, evolving the model from the inputs presented this cycle.
  task automatic tick();
    logic take, tk;
    logic [63:0] r1, r2, alu, res, tgt;
    take = id_valid && ref_ready() && !m_redir && !flush;
    r1   = ref_fwd(id_rs1_addr, id_rs1_data);
    r2   = ref_fwd(id_rs2_addr, id_rs2_data);
    alu  = ref_alu(id_alu_op, id_a_sel ? id_pc : r1, id_b_sel ? id_imm : r2);
    tk   = ref_taken(id_br_type, r1, r2);
    res  = (id_br_type == 3'd7) ? id_pc + 64'd4 : alu;
    tgt  = (id_br_type == 3'd7) ? (alu & ~64'd1) : id_pc + id_imm;
    @(posedge clk);
    #1;
    m_redir = take && tk;
    if (take && tk) m_redir_pc = tgt;
    if (flush) m_valid = 0;
    else if (take) begin
      m_valid = 1; m_result = res; m_store = r2; m_rd = id_rd_addr; m_we = id_rd_we; m_pc = id_pc;
    end else if (ex_ready) m_valid = 0;
  endtask

  task automatic set_instr(input logic [63:0] pc, input logic [4:0] rs1, input logic [63:0] d1,
                           input logic [4:0] rs2, input logic [63:0] d2, input logic [63:0] imm,
                           input logic [4:0] rd, input logic we, input logic [3:0] op,
                           input logic asel, input logic bsel, input logic [2:0] br);
    id_valid = 1; id_pc = pc; id_rs1_addr = rs1; id_rs1_data = d1; id_rs2_addr = rs2;
    id_rs2_data = d2; id_imm = imm; id_rd_addr = rd; id_rd_we = we; id_alu_op = op;
    id_a_sel = asel; id_b_sel = bsel; id_br_type = br;
  endtask

  task automatic idle();
    id_valid = 0; id_br_type = 3'd0;
  endtask

  task automatic test_reset();
    rst_n = 0; flush = 0; ex_ready = 1; mem_we = 0; wb_we = 0; mem_rd = 0; wb_rd = 0;
    mem_data = 0; wb_data = 0;
    set_instr(64'd0, 5'd0, 64'd0, 5'd0, 64'd0, 64'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
    idle();
    model_reset();
    #12;
    checks++;
    if ({ex_valid, redirect, ex_we} !== 3'b000 || ex_result !== 0 || ex_store !== 0 ||
        ex_rd !== 0 || ex_pc !== 0 || redirect_pc !== 0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b r=%b we=%b res=%h st=%h rd=%0d pc=%h rpc=%h want all zero",
               ex_valid, redirect, ex_we, ex_result, ex_store, ex_rd, ex_pc, redirect_pc);
    end
    checks++;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready got %b want 1", id_ready); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_back_to_back();
    set_instr(64'h1000, 5'd0, 64'd0, 5'd0, 64'd0, 64'd5, 5'd1, 1'b1, 4'd0, 1'b0, 1'b1, 3'd0);
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_result !== 64'd5) begin
      errors++; $display("FAIL b2b_addi got v=%b res=%h want v=1 res=5", ex_valid, ex_result);
    end
    set_instr(64'h1004, 5'd1, 64'hdead, 5'd1, 64'hbeef, 64'd0, 5'd2, 1'b1, 4'd0, 1'b0, 1'b0, 3'd0);
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_result !== 64'd10 || ex_rd !== 5'd2 || ex_pc !== 64'h1004) begin
      errors++; $display("FAIL b2b_add got v=%b res=%h rd=%0d pc=%h want v=1 res=a rd=2 pc=1004",
                         ex_valid, ex_result, ex_rd, ex_pc);
    end
    idle();
    tick();
    checks++;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got v=%b want 0", ex_valid); end
  endtask

  task automatic test_bypass_priority();
    mem_we = 1; mem_rd = 5'd3; mem_data = 64'h11;
    wb_we  = 1; wb_rd  = 5'd3; wb_data  = 64'h22;
    set_instr(64'h2000, 5'd3, 64'h99, 5'd0, 64'd0, 64'd0, 5'd4, 1'b1, 4'd1, 1'b0, 1'b0, 3'd0);
    tick();
    checks++;
    if (ex_result !== 64'h11 || ex_store !== 64'd0) begin
      errors++; $display("FAIL bypass_mem_over_wb got res=%h st=%h want res=11 st=0", ex_result, ex_store);
    end
    mem_rd = 5'd0; wb_rd = 5'd0;
    set_instr(64'h2004, 5'd0, 64'h99, 5'd0, 64'h5, 64'd0, 5'd4, 1'b1, 4'd1, 1'b0, 1'b0, 3'd0);
    tick();
    checks++;
    if (ex_result !== 64'h94 || ex_store !== 64'h5) begin
      errors++; $display("FAIL bypass_x0 got res=%h st=%h want res=94 st=5", ex_result, ex_store);
    end
    mem_we = 0; wb_we = 0;
    idle();
    tick();
  endtask

  task automatic test_branch();
    set_instr(64'h100, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'd1, 64'h20, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd3);
    tick();
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 64'h120 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL blt_taken got r=%b rpc=%h v=%b want r=1 rpc=120 v=1", redirect, redirect_pc, ex_valid);
    end
    idle();
    tick();
    checks++;
    if (redirect !== 1'b0 || ex_valid !== 1'b0) begin
      errors++; $display("FAIL blt_one_cycle got r=%b v=%b want r=0 v=0", redirect, ex_valid);
    end
    set_instr(64'h100, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'd1, 64'h20, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd5);
    tick();
    checks++;
    if (redirect !== 1'b0 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL bltu_not_taken got r=%b v=%b want r=0 v=1", redirect, ex_valid);
    end
    idle();
    tick();
  endtask

  task automatic test_jalr();
    set_instr(64'h80, 5'd7, 64'h2001, 5'd0, 64'd0, 64'd0, 5'd1, 1'b1, 4'd0, 1'b0, 1'b1, 3'd7);
    tick();
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 64'h2000 || ex_result !== 64'h84 || ex_rd !== 5'd1) begin
      errors++; $display("FAIL jalr got r=%b rpc=%h res=%h rd=%0d want r=1 rpc=2000 res=84 rd=1",
                         redirect, redirect_pc, ex_result, ex_rd);
    end
    ex_ready = 0;
    set_instr(64'h84, 5'd0, 64'd0, 5'd0, 64'd0, 64'h77, 5'd9, 1'b1, 4'd0, 1'b0, 1'b1, 3'd0);
    #1;
    checks++;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL squash_ready got %b want 1", id_ready); end
    tick();
    checks++;
    if (redirect !== 1'b0 || ex_valid !== 1'b1 || ex_result !== 64'h84 || ex_rd !== 5'd1) begin
      errors++; $display("FAIL squash_discard got r=%b v=%b res=%h rd=%0d want r=0 v=1 res=84 rd=1",
                         redirect, ex_valid, ex_result, ex_rd);
    end
    ex_ready = 1;
    idle();
    tick();
    checks++;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL squash_drain got v=%b want 0", ex_valid); end
  endtask

  task automatic test_stall();
    set_instr(64'h300, 5'd0, 64'd0, 5'd0, 64'd0, 64'h55, 5'd10, 1'b1, 4'd0, 1'b0, 1'b1, 3'd0);
    tick();
    ex_ready = 0;
    set_instr(64'h304, 5'd0, 64'd0, 5'd0, 64'd0, 64'h66, 5'd11, 1'b1, 4'd0, 1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0", i, id_ready); end
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_result !== 64'h55 || ex_rd !== 5'd10 || ex_pc !== 64'h300) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b res=%h rd=%0d pc=%h want v=1 res=55 rd=10 pc=300",
                           i, ex_valid, ex_result, ex_rd, ex_pc);
      end
    end
    ex_ready = 1;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", id_ready); end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_result !== 64'h66 || ex_rd !== 5'd11) begin
      errors++; $display("FAIL release_load got v=%b res=%h rd=%0d want v=1 res=66 rd=11", ex_valid, ex_result, ex_rd);
    end
    idle();
    tick();
  endtask

  task automatic test_flush();
    flush = 1;
    set_instr(64'h40, 5'd12, 64'd7, 5'd13, 64'd7, 64'h10, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd1);
    tick();
    checks++;
    if (ex_valid !== 1'b0 || redirect !== 1'b0) begin
      errors++; $display("FAIL flush_beq got v=%b r=%b want v=0 r=0", ex_valid, redirect);
    end
    flush = 0;
    idle();
    tick();
  endtask

  task automatic test_async_reset();
    set_instr(64'h500, 5'd0, 64'd0, 5'd0, 64'd0, 64'h123, 5'd14, 1'b1, 4'd0, 1'b0, 1'b1, 3'd7);
    tick();
    ex_ready = 0;
    idle();
    tick();
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({ex_valid, redirect, ex_we} !== 3'b000 || ex_result !== 0 || ex_store !== 0 ||
        ex_rd !== 0 || ex_pc !== 0 || redirect_pc !== 0 || id_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset got v=%b r=%b we=%b res=%h rd=%0d pc=%h rdy=%b want zeros rdy=1",
                         ex_valid, redirect, ex_we, ex_result, ex_rd, ex_pc, id_ready);
    end
    model_reset();
    ex_ready = 1;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_instr({48'd0, 16'($urandom)} & ~64'd3, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                5'($urandom_range(0, 7)), ($urandom % 3 == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom},
                ($urandom % 2 == 0) ? 64'($urandom_range(0, 63)) : {$urandom, $urandom},
                5'($urandom_range(0, 7)), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                ($urandom % 2 == 0) ? 3'd0 : 3'($urandom));
      id_valid = ($urandom % 4) != 0;
      ex_ready = ($urandom % 4) != 0;
      flush    = ($urandom % 32) == 0;
      mem_we = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_data = {$urandom, $urandom};
      wb_we  = 1'($urandom); wb_rd  = 5'($urandom_range(0, 7)); wb_data  = {$urandom, $urandom};
      #1;
      checks++;
      if (id_ready !== ref_ready()) begin
        errors++; $display("FAIL rand_ready[%0d] got %b want %b", i, id_ready, ref_ready());
      end
      tick();
      checks++;
      if (ex_valid !== m_valid || redirect !== m_redir) begin
        errors++; $display("FAIL rand_ctrl[%0d] got v=%b r=%b want v=%b r=%b", i, ex_valid, redirect, m_valid, m_redir);
      end
      if (m_valid) begin
        checks++;
        if (ex_result !== m_result || ex_store !== m_store || ex_rd !== m_rd || ex_we !== m_we || ex_pc !== m_pc) begin
          errors++; $display("FAIL rand_slot[%0d] got res=%h st=%h rd=%0d we=%b pc=%h want res=%h st=%h rd=%0d we=%b pc=%h",
                             i, ex_result, ex_store, ex_rd, ex_we, ex_pc, m_result, m_store, m_rd, m_we, m_pc);
        end
      end
      if (m_redir) begin
        checks++;
        if (redirect_pc !== m_redir_pc) begin
          errors++; $display("FAIL rand_target[%0d] got %h want %h", i, redirect_pc, m_redir_pc);
        end
      end
    end
    flush = 0; mem_we = 0; wb_we = 0; ex_ready = 1;
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bypass_priority();
    test_branch();
    test_jalr();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
